pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline.

---
 rtl/pipeline_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: memory-wait freeze, load-use bubbles,
// redirect squashes, saturating performance counters and a stall watchdog.
module pipeline_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] stall_events,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] bubble_count,
    output logic             err_timeout,
    output logic             dbg_state
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // The watchdog count never needs to exceed TIMEOUT-1, so it parks there.
    localparam int              WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               i_done_q, i_done_d;
    logic               d_done_q, d_done_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]   stall_events_q, stall_events_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;
    logic [CNT_W-1:0]   bubble_count_q, bubble_count_d;
    logic               err_timeout_q, err_timeout_d;

    logic               i_ok;
    logic               d_ok;
    logic               advance;
    logic               load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        i_ok    = ~imem_req | imem_resp | i_done_q;
        d_ok    = ~dmem_req | dmem_resp | d_done_q;
        advance = i_ok & d_ok;

        load_use = ex_is_load && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));

        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;

        state_d        = state_q;
        i_done_d       = advance ? 1'b0 : (i_done_q | imem_resp);
        d_done_d       = advance ? 1'b0 : (d_done_q | dmem_resp);
        wd_cnt_d       = wd_cnt_q;
        stall_cycles_d = stall_cycles_q;
        stall_events_d = stall_events_q;
        flush_count_d  = flush_count_q;
        bubble_count_d = bubble_count_q;
        err_timeout_d  = err_timeout_q;

        // Redirect outranks load-use: the dependent ID instruction is on the wrong path anyway.
        if (!rst) begin
            if (!advance) begin
                // pipe frozen, every enable stays low
            end else if (ex_redirect) begin
                load_pc       = 1'b1;
                load_if_id    = 1'b1;
                load_id_ex    = 1'b1;
                load_ex_mem   = 1'b1;
                load_mem_wb   = 1'b1;
                flush_if_id   = 1'b1;
                flush_id_ex   = 1'b1;
                flush_count_d = sat_inc(flush_count_q);
            end else if (load_use) begin
                load_id_ex     = 1'b1;
                flush_id_ex    = 1'b1;
                load_ex_mem    = 1'b1;
                load_mem_wb    = 1'b1;
                bubble_count_d = sat_inc(bubble_count_q);
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
            end
        end

        if (advance) begin
            state_d  = ST_RUN;
            wd_cnt_d = '0;
        end else begin
            state_d        = ST_WAIT;
            stall_cycles_d = sat_inc(stall_cycles_q);
            if (state_q == ST_RUN) begin
                stall_events_d = sat_inc(stall_events_q);
            end
            if (wd_cnt_q == WD_MAX) begin
                err_timeout_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            i_done_q       <= 1'b0;
            d_done_q       <= 1'b0;
            wd_cnt_q       <= '0;
            stall_cycles_q <= '0;
            stall_events_q <= '0;
            flush_count_q  <= '0;
            bubble_count_q <= '0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            i_done_q       <= i_done_d;
            d_done_q       <= d_done_d;
            wd_cnt_q       <= wd_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            stall_events_q <= stall_events_d;
            flush_count_q  <= flush_count_d;
            bubble_count_q <= bubble_count_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign stall_events = stall_events_q;
    assign flush_count  = flush_count_q;
    assign bubble_count = bubble_count_q;
    assign err_timeout  = err_timeout_q;
    assign dbg_state    = (state_q == ST_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: memory stalls, load-use, redirects, reset drop, watchdog.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic imem_req, imem_resp, dmem_req, dmem_resp;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;

    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex;
    logic [31:0] stall_cycles, stall_events, flush_count, bubble_count;
    logic err_timeout, dbg_state;

    logic s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
    logic s_flush_if_id, s_flush_id_ex;
    logic [1:0] s_stall_cycles, s_stall_events, s_flush_count, s_bubble_count;
    logic s_err_timeout, s_dbg_state;

    logic [4:0] loads;
    logic [1:0] flushes;
    assign loads   = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    assign flushes = {flush_if_id, flush_id_ex};

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_cycles(stall_cycles), .stall_events(stall_events),
        .flush_count(flush_count), .bubble_count(bubble_count),
        .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    pipeline_hazard_ctrl #(.CNT_W(2), .TIMEOUT(8)) dut_sat (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .load_pc(s_load_pc), .load_if_id(s_load_if_id), .load_id_ex(s_load_id_ex),
        .load_ex_mem(s_load_ex_mem), .load_mem_wb(s_load_mem_wb),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .stall_cycles(s_stall_cycles), .stall_events(s_stall_events),
        .flush_count(s_flush_count), .bubble_count(s_bubble_count),
        .err_timeout(s_err_timeout), .dbg_state(s_dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs are already applied; let them settle, check the same-cycle enables, then clock.
    task automatic cyc(input string tag, input logic [4:0] exp_loads, input logic [1:0] exp_flush);
        #2;
        check({tag, ".loads"}, 32'(loads), 32'(exp_loads));
        check({tag, ".flush"}, 32'(flushes), 32'(exp_flush));
        step();
    endtask

    task automatic idle_inputs();
        imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_is_load = 0; ex_rd = 0; ex_redirect = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] exp_v;
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        // Reset held: no requests, so only the reset gating can keep enables low.
        #2;
        check("rst.loads", 32'(loads), 32'h0);
        check("rst.flush", 32'(flushes), 32'h0);
        check("rst.stall_cycles", stall_cycles, 0);
        check("rst.bubble_count", bubble_count, 0);
        check("rst.state", 32'(dbg_state), 0);
        check("rst.err", 32'(err_timeout), 0);

        rst = 1'b0;
        cyc("idle", 5'h1f, 2'b00);

        // imem resp in cycle 3, dmem resp in cycle 6
        for (int c = 1; c <= 6; c++) exp_q.push_back((c < 6) ? 32'h0 : 32'h1f);
        imem_req = 1; dmem_req = 1;
        for (int c = 1; c <= 6; c++) begin
            imem_resp = (c == 3);
            dmem_resp = (c == 6);
            #2;
            exp_v = exp_q.pop_front();
            check($sformatf("stall.c%0d.loads", c), 32'(loads), exp_v);
            if (c == 2) check("stall.state_wait", 32'(dbg_state), 1);
            step();
        end
        idle_inputs();
        check("stall.stall_cycles", stall_cycles, 5);
        check("stall.stall_events", stall_events, 1);
        check("stall.state_run", 32'(dbg_state), 0);
        check("sat.stall_cycles", 32'(s_stall_cycles), 3);

        // load-use via rs2
        ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        cyc("lu_rs2", 5'b00111, 2'b01);
        check("lu_rs2.bubble_count", bubble_count, 1);
        check("lu_rs2.flush_count", flush_count, 0);

        // load-use via rs1
        id_use_rs2 = 0; id_rs2 = 0; id_rs1 = 5; id_use_rs1 = 1;
        cyc("lu_rs1", 5'b00111, 2'b01);
        check("lu_rs1.bubble_count", bubble_count, 2);

        // register matches but is not read
        id_use_rs1 = 0;
        cyc("lu_nouse", 5'h1f, 2'b00);
        check("lu_nouse.bubble_count", bubble_count, 2);

        // redirect beats load-use
        id_rs2 = 5; id_use_rs2 = 1; ex_redirect = 1;
        cyc("redir", 5'h1f, 2'b11);
        check("redir.flush_count", flush_count, 1);
        check("redir.bubble_count", bubble_count, 2);

        // x0 never creates a hazard
        idle_inputs();
        ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        cyc("x0", 5'h1f, 2'b00);
        check("x0.bubble_count", bubble_count, 2);

        // redirect held through a D-memory stall, squash happens when it releases
        idle_inputs();
        dmem_req = 1; ex_redirect = 1;
        cyc("redir_stall", 5'h00, 2'b00);
        dmem_resp = 1;
        cyc("redir_release", 5'h1f, 2'b11);
        idle_inputs();
        check("redir_stall.flush_count", flush_count, 2);
        check("redir_stall.stall_cycles", stall_cycles, 6);
        check("redir_stall.stall_events", stall_events, 2);

        // dmem answers first and is remembered until imem answers
        imem_req = 1; dmem_req = 1; dmem_resp = 1;
        cyc("early_d", 5'h00, 2'b00);
        dmem_resp = 0; imem_resp = 1;
        cyc("late_i", 5'h1f, 2'b00);
        idle_inputs();

        // reset mid-stall drops the remembered imem response
        imem_req = 1; dmem_req = 1; imem_resp = 1;
        cyc("rst_mid.resp", 5'h00, 2'b00);
        imem_resp = 0; rst = 1;
        cyc("rst_mid.rst", 5'h00, 2'b00);
        rst = 0; dmem_resp = 1;
        cyc("rst_mid.dropped", 5'h00, 2'b00);
        dmem_resp = 0; imem_resp = 1;
        cyc("rst_mid.release", 5'h1f, 2'b00);
        idle_inputs();
        check("rst_mid.stall_cycles", stall_cycles, 1);
        check("rst_mid.stall_events", stall_events, 1);

        // watchdog: TIMEOUT=8, sets after the 8th consecutive stalled cycle
        dmem_req = 1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 7) check("wd.c7.err", 32'(err_timeout), 0);
            if (c == 8) check("wd.c8.err", 32'(err_timeout), 1);
        end
        check("wd.c10.err", 32'(err_timeout), 1);
        dmem_resp = 1;
        cyc("wd.release", 5'h1f, 2'b00);
        idle_inputs();
        step();
        check("wd.held", 32'(err_timeout), 1);
        rst = 1;
        step();
        check("wd.rst_clear", 32'(err_timeout), 0);
        rst = 0;
        step();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
